text_line_fetch: RTL
====================

# text_line_fetch

Display-side reader of the text RAM, downstream of the text-editing controller that writes it. During each horizontal blank it fetches the text row needed for the next scan line from the RAM's read port into a line register. During active video it streams the 32-bit character cell, glyph coordinates and cursor flag for every pixel to the glyph/colour renderer, through a fixed two-cycle pipeline.

## Interface
Parameters:
- CONSOLE_COLUMNS, 80: characters per text row.
- CONSOLE_LINES, 30: text rows per screen.
- CHAR_WIDTH, 32: bits per character cell; [7:0] is the code and the upper bits are attributes.
- FONT_W, 8; FONT_H, 16: glyph size in pixels.
- V_ACTIVE, 480: active scan lines.
- BLINK_FRAMES, 32: frames per cursor blink half-period.

Ports:
- clk  in  1  pixel clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- line_end  in  1  one-cycle pulse at the start of horizontal blank.
- next_y  in  11  scan line to be displayed after this blank; valid with line_end.
- vga_x, vga_y  in  11 each  current pixel coordinates.
- vga_de  in  1  active video.
- cursor_row, cursor_col  in  8 each  cursor cell position.
- cursor_en  in  1  cursor visible (DECTCEM).
- ram_rd_addr  out  8  text RAM read row; registered.
- ram_rd_data  in  CONSOLE_COLUMNS*CHAR_WIDTH  RAM row; valid 2 cycles after the address.
- pix_valid  out  1  delayed vga_de.
- pix_char  out  CHAR_WIDTH  cell under the pixel.
- pix_glyph_row  out  4  vga_y mod FONT_H.
- pix_glyph_col  out  3  vga_x mod FONT_W.
- pix_cursor  out  1  pixel lies in the cursor cell and the blink phase is on.
- busy  out  1  fetch in progress.
- overrun  out  1  sticky; set when line_end arrives while busy.

## Operation
- Fetch FSM states: IDLE, ADDR, WAIT, CAPTURE.
- IDLE → ADDR on line_end, but only if all of these hold:
  - next_y < V_ACTIVE;
  - next_y mod FONT_H == 0;
  - next_y/FONT_H < CONSOLE_LINES.
  On that edge, ram_rd_addr <= next_y/FONT_H.
- If the conditions do not hold, line_end is ignored and disp_buf is kept. A scan line that is not the first line of a text row reuses the row already held.
- ADDR → WAIT → CAPTURE → IDLE, unconditionally. In CAPTURE, disp_buf <= ram_rd_data.
- busy is high in ADDR, WAIT and CAPTURE.
- line_end while busy is ignored and sets overrun. overrun clears only on rst.
- Pixel pipeline, stage 1 (registered):
  - col = vga_x / FONT_W;
  - gx = vga_x mod FONT_W;
  - gy = vga_y mod FONT_H;
  - row = vga_y / FONT_H;
  - de.
- Pixel pipeline, stage 2 (registered):
  - pix_char = disp_buf cell[col]. If col >= CONSOLE_COLUMNS, output the blank cell 32'h0007fc20.
  - pix_cursor = cursor_en & blink & (row == cursor_row) & (col == cursor_col) & de.
- Blink: frame_cnt increments on line_end with next_y == 0. blink toggles when frame_cnt reaches BLINK_FRAMES-1, and frame_cnt then wraps to 0.
- Reset values:
  - FSM in IDLE; ram_rd_addr 0; busy 0; overrun 0; blink 1; frame_cnt 0.
  - disp_buf all cells 32'h0007fc20.
  - All pix_* outputs 0.
- Reset during a fetch aborts it. disp_buf returns to blank and the pending RAM data is discarded.

## Timing
- line_end sampled at edge E0:
  - ram_rd_addr valid after E0;
  - data sampled at E3 (CAPTURE);
  - disp_buf updated after E3;
  - busy high between E0 and E3.
- Fetch occupies 3 cycles. With 640x480 timing, horizontal blank is 160 cycles, so disp_buf changes only during blank.
- Pixel latency is 2 cycles: inputs sampled at edge E0 appear on pix_* after E1.
- The last active pixel's stage-2 read of disp_buf precedes the first disp_buf write. This holds because line_end follows de falling and the fetch takes ≥3 cycles.
- Column index arithmetic is 8-bit unsigned. Row compare is 8-bit; vga_y/FONT_H is truncated to 8 bits.

## Structure
- Shared package DataType.svh holds:
  - CONSOLE_COLUMNS, CONSOLE_LINES, TEXT_RAM_CHAR_WIDTH, TEXT_RAM_LINE_WIDTH;
  - the blank-cell constant 32'h0007fc20;
  - an optional Cell_t struct (code, charset, fg, bg, underline, bright, negative, blink) shared with the writer side.
- One sub-module, cursor_blink: frame counter plus blink toggle, inputs line_end and next_y, output blink.

## Test plan
- Reset with RAM row 0 = all 'A' (32'h0007fc41). Then line_end with next_y=0: ram_rd_addr=0 after E0, busy for 3 cycles. Pixel (x=0,y=0) → pix_char=32'h0007fc41 two cycles later.
- next_y=17 (not the first line of a row): no fetch, ram_rd_addr unchanged, busy stays 0.
- next_y=480 or next_y=496: no fetch.
- RAM row 2 cell 79 = 32'h12345678. Fetch row 2, then pixel x=639,y=40 → pix_char=32'h12345678, glyph_col=7, glyph_row=8.
- Second line_end one cycle after the first → ignored and overrun=1. overrun stays 1 until rst.
- cursor (3,5) with cursor_en=1: pixel x=40..47, y=48..63 → pix_cursor=1. pix_cursor goes to 0 after 32 next_y==0 frames, and returns to 1 after 64.
- rst asserted in WAIT: FSM returns to IDLE, disp_buf reads 32'h0007fc20, and the next CAPTURE does not occur.

Source files
------------

// File: rtl/text_line_fetch_pkg.sv
// Shared text RAM geometry and cell format, common to the writer and the display reader.
package text_line_fetch_pkg;

    localparam int CONSOLE_COLUMNS     = 80;
    localparam int CONSOLE_LINES       = 30;
    localparam int TEXT_RAM_CHAR_WIDTH = 32;
    localparam int TEXT_RAM_LINE_WIDTH = CONSOLE_COLUMNS * TEXT_RAM_CHAR_WIDTH;

    // Space character with the default attribute set; shown wherever no text exists.
    localparam logic [31:0] BLANK_CELL = 32'h0007fc20;

    typedef struct packed {
        logic [8:0] reserved;
        logic       blink;
        logic       negative;
        logic       bright;
        logic       underline;
        logic [3:0] bg;
        logic [3:0] fg;
        logic [2:0] charset;
        logic [7:0] code;
    } Cell_t;

endpackage

// File: rtl/text_line_fetch_cursor_blink.sv
// Cursor blink phase: counts frames (line_end with next_y == 0) and flips every BLINK_FRAMES.
module cursor_blink #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_end,
    input  logic [10:0] next_y,
    output logic        blink
);
    import text_line_fetch_pkg::*;

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (line_end && (next_y == 11'd0)) begin
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign blink = r_blink;

endmodule

// File: rtl/text_line_fetch.sv
// Fetches one text row per horizontal blank into a line buffer and streams cells to the renderer
// through a fixed two-stage pixel pipeline.
module text_line_fetch #(
    parameter int CONSOLE_COLUMNS = 80,
    parameter int CONSOLE_LINES   = 30,
    parameter int CHAR_WIDTH      = 32,
    parameter int FONT_W          = 8,
    parameter int FONT_H          = 16,
    parameter int V_ACTIVE        = 480,
    parameter int BLINK_FRAMES    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 line_end,
    input  logic [10:0]                          next_y,
    input  logic [10:0]                          vga_x,
    input  logic [10:0]                          vga_y,
    input  logic                                 vga_de,
    input  logic [7:0]                           cursor_row,
    input  logic [7:0]                           cursor_col,
    input  logic                                 cursor_en,
    output logic [7:0]                           ram_rd_addr,
    input  logic [CONSOLE_COLUMNS*CHAR_WIDTH-1:0] ram_rd_data,
    output logic                                 pix_valid,
    output logic [CHAR_WIDTH-1:0]                pix_char,
    output logic [3:0]                           pix_glyph_row,
    output logic [2:0]                           pix_glyph_col,
    output logic                                 pix_cursor,
    output logic                                 busy,
    output logic                                 overrun
);
    import text_line_fetch_pkg::*;

    localparam logic [CHAR_WIDTH-1:0] BLANK = CHAR_WIDTH'(BLANK_CELL);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]            r_state;
    logic [7:0]            r_ram_rd_addr;
    logic                  r_overrun;
    logic [CHAR_WIDTH-1:0] r_disp_buf [CONSOLE_COLUMNS];

    logic                  w_busy;
    logic                  w_row_start;
    logic                  w_blink;
    logic [CHAR_WIDTH-1:0] w_cell;

    logic [7:0]            r_col_p1;
    logic [7:0]            r_row_p1;
    logic [2:0]            r_gx_p1;
    logic [3:0]            r_gy_p1;
    logic                  r_de_p1;

    logic                  r_vld_p2;
    logic [CHAR_WIDTH-1:0] r_char_p2;
    logic [3:0]            r_gy_p2;
    logic [2:0]            r_gx_p2;
    logic                  r_cursor_p2;

    assign w_busy = (r_state != S_IDLE);

    // Only the first scan line of a visible text row needs a new fetch; the rest reuse the buffer.
    assign w_row_start = (next_y < 11'(V_ACTIVE))
                      && ((next_y % 11'(FONT_H)) == 11'd0)
                      && ((next_y / 11'(FONT_H)) < 11'(CONSOLE_LINES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ram_rd_addr <= 8'd0;
            r_overrun     <= 1'b0;
        end else begin
            if (line_end && w_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (line_end && w_row_start) begin
                        r_state       <= S_ADDR;
                        r_ram_rd_addr <= 8'(next_y / 11'(FONT_H));
                    end
                end
                S_ADDR:    r_state <= S_WAIT;
                S_WAIT:    r_state <= S_CAPTURE;
                S_CAPTURE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CONSOLE_COLUMNS; c++) begin
                r_disp_buf[c] <= BLANK;
            end
        end else if (r_state == S_CAPTURE) begin
            for (int c = 0; c < CONSOLE_COLUMNS; c++) begin
                r_disp_buf[c] <= ram_rd_data[c*CHAR_WIDTH +: CHAR_WIDTH];
            end
        end
    end

    cursor_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cursor_blink (
        .clk      (clk),
        .rst      (rst),
        .line_end (line_end),
        .next_y   (next_y),
        .blink    (w_blink)
    );

    // Stage 1: split pixel coordinates into cell index and glyph offset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_p1 <= 8'd0;
            r_row_p1 <= 8'd0;
            r_gx_p1  <= 3'd0;
            r_gy_p1  <= 4'd0;
            r_de_p1  <= 1'b0;
        end else begin
            r_col_p1 <= 8'(vga_x / 11'(FONT_W));
            r_row_p1 <= 8'(vga_y / 11'(FONT_H));
            r_gx_p1  <= 3'(vga_x % 11'(FONT_W));
            r_gy_p1  <= 4'(vga_y % 11'(FONT_H));
            r_de_p1  <= vga_de;
        end
    end

    // Columns past the end of the row (horizontal overscan) show a blank cell.
    always_comb begin
        w_cell = BLANK;
        for (int c = 0; c < CONSOLE_COLUMNS; c++) begin
            if (r_col_p1 == 8'(c)) begin
                w_cell = r_disp_buf[c];
            end
        end
    end

    // Stage 2: cell lookup and cursor hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2    <= 1'b0;
            r_char_p2   <= '0;
            r_gy_p2     <= 4'd0;
            r_gx_p2     <= 3'd0;
            r_cursor_p2 <= 1'b0;
        end else begin
            r_vld_p2    <= r_de_p1;
            r_char_p2   <= w_cell;
            r_gy_p2     <= r_gy_p1;
            r_gx_p2     <= r_gx_p1;
            r_cursor_p2 <= cursor_en & w_blink & (r_row_p1 == cursor_row)
                         & (r_col_p1 == cursor_col) & r_de_p1;
        end
    end

    assign ram_rd_addr   = r_ram_rd_addr;
    assign busy          = w_busy;
    assign overrun       = r_overrun;
    assign pix_valid     = r_vld_p2;
    assign pix_char      = r_char_p2;
    assign pix_glyph_row = r_gy_p2;
    assign pix_glyph_col = r_gx_p2;
    assign pix_cursor    = r_cursor_p2;

endmodule
